// File: rtl/fakeram_arbiter_1024x46.sv
// Round-robin arbiter sharing one 1024x46 single-port fakeram between two
// valid/ready requesters, with an optional zero-fill sweep after reset.
module fakeram_arbiter_1024x46 #(
    parameter int BITS       = 46,
    parameter int WORD_DEPTH = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter bit INIT_ZERO  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  a_v_i,
    output logic                  a_ready_o,
    input  logic                  a_we_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [BITS-1:0]       a_wd_i,
    input  logic [BITS-1:0]       a_wmask_i,
    output logic                  a_rsp_v_o,
    output logic [BITS-1:0]       a_rsp_data_o,
    input  logic                  a_rsp_ready_i,

    input  logic                  b_v_i,
    output logic                  b_ready_o,
    input  logic                  b_we_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [BITS-1:0]       b_wd_i,
    input  logic [BITS-1:0]       b_wmask_i,
    output logic                  b_rsp_v_o,
    output logic [BITS-1:0]       b_rsp_data_o,
    input  logic                  b_rsp_ready_i,

    output logic                  ram_ce_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [BITS-1:0]       ram_wd_o,
    output logic [BITS-1:0]       ram_wmask_o,
    input  logic [BITS-1:0]       ram_rd_i,

    output logic                  init_done_o
);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;
    localparam logic [0:0] S_RST  = INIT_ZERO ? S_INIT : S_RUN;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(WORD_DEPTH - 1);

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rr_q, rr_d;
    logic                  a_inf_q, a_inf_d;
    logic                  b_inf_q, b_inf_d;
    logic                  a_rv_q, a_rv_d;
    logic                  b_rv_q, b_rv_d;
    logic [BITS-1:0]       a_rd_q, a_rd_d;
    logic [BITS-1:0]       b_rd_q, b_rd_d;

    logic in_run;
    logic in_init;
    logic a_elig;
    logic b_elig;
    logic a_gnt;
    logic b_gnt;

    // Outputs are forced low while reset is held, even in combinational paths.
    assign in_run  = rst_n && (state_q == S_RUN);
    assign in_init = rst_n && (state_q == S_INIT);

    assign a_elig = a_v_i &&
                    (a_we_i || (!a_inf_q && (!a_rv_q || a_rsp_ready_i)));
    assign b_elig = b_v_i &&
                    (b_we_i || (!b_inf_q && (!b_rv_q || b_rsp_ready_i)));

    // rr_q == 0 favours A, rr_q == 1 favours B.
    assign a_gnt = in_run && a_elig && (!b_elig || !rr_q);
    assign b_gnt = in_run && b_elig && (!a_elig || rr_q);

    assign a_ready_o    = a_gnt;
    assign b_ready_o    = b_gnt;
    assign a_rsp_v_o    = a_rv_q;
    assign b_rsp_v_o    = b_rv_q;
    assign a_rsp_data_o = a_rd_q;
    assign b_rsp_data_o = b_rd_q;
    assign init_done_o  = in_run;

    always_comb begin
        ram_ce_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wd_o    = '0;
        ram_wmask_o = '0;
        unique case (1'b1)
            in_init: begin
                ram_ce_o    = 1'b1;
                ram_we_o    = 1'b1;
                ram_addr_o  = cnt_q;
                ram_wmask_o = '1;
            end
            a_gnt: begin
                ram_ce_o    = 1'b1;
                ram_we_o    = a_we_i;
                ram_addr_o  = a_addr_i;
                ram_wd_o    = a_wd_i;
                ram_wmask_o = a_wmask_i;
            end
            b_gnt: begin
                ram_ce_o    = 1'b1;
                ram_we_o    = b_we_i;
                ram_addr_o  = b_addr_i;
                ram_wd_o    = b_wd_i;
                ram_wmask_o = b_wmask_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                state_d = S_RUN;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (a_gnt) begin
            rr_d = 1'b1;
        end else if (b_gnt) begin
            rr_d = 1'b0;
        end
    end

    assign a_inf_d = a_gnt && !a_we_i;
    assign b_inf_d = b_gnt && !b_we_i;

    // Macro data is valid the cycle after the read strobe; capture it then.
    always_comb begin
        a_rv_d = a_rv_q;
        a_rd_d = a_rd_q;
        if (a_inf_q) begin
            a_rv_d = 1'b1;
            a_rd_d = ram_rd_i;
        end else if (a_rsp_ready_i) begin
            a_rv_d = 1'b0;
        end
    end

    always_comb begin
        b_rv_d = b_rv_q;
        b_rd_d = b_rd_q;
        if (b_inf_q) begin
            b_rv_d = 1'b1;
            b_rd_d = ram_rd_i;
        end else if (b_rsp_ready_i) begin
            b_rv_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            a_inf_q <= 1'b0;
            b_inf_q <= 1'b0;
            a_rv_q  <= 1'b0;
            b_rv_q  <= 1'b0;
            a_rd_q  <= '0;
            b_rd_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            a_inf_q <= a_inf_d;
            b_inf_q <= b_inf_d;
            a_rv_q  <= a_rv_d;
            b_rv_q  <= b_rv_d;
            a_rd_q  <= a_rd_d;
            b_rd_q  <= b_rd_d;
        end
    end

endmodule

// File: doc/fakeram_arbiter_1024x46.md
Name: fakeram_arbiter_1024x46

Overview:
- Shares one single-port 1024x46 fakeram macro between two requesters, A and B, using round-robin arbitration.
- Requests use a valid/ready handshake. Read responses return through a per-port 1-entry buffer with backpressure.
- After reset, an optional init sequencer zero-fills the whole macro before any requests are accepted.
- Sits between core-side clients and the hard macro in the manycore tile; drives the macro's ce/we/addr/wd/mask pins directly.

Parameters:
- BITS, 46, data and mask width.
- WORD_DEPTH, 1024, number of words.
- ADDR_WIDTH, 10, address width; must equal log2(WORD_DEPTH).
- INIT_ZERO, 1, 1 = zero-fill memory after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- a_v_i  in  1  port A request valid.
- a_ready_o  out  1  port A request accepted this cycle when high together with a_v_i.
- a_we_i  in  1  1 = write, 0 = read.
- a_addr_i  in  ADDR_WIDTH  request address.
- a_wd_i  in  BITS  write data.
- a_wmask_i  in  BITS  per-bit write enable; 1 = write that bit.
- a_rsp_v_o  out  1  read response valid.
- a_rsp_data_o  out  BITS  read response data.
- a_rsp_ready_i  in  1  consumer takes the response.
- b_*  (same nine ports as A, for port B).
- ram_ce_o  out  1  macro chip enable.
- ram_we_o  out  1  macro write enable.
- ram_addr_o  out  ADDR_WIDTH  macro address.
- ram_wd_o  out  BITS  macro write data.
- ram_wmask_o  out  BITS  macro write mask.
- ram_rd_i  in  BITS  macro read data; valid the cycle after a read ce.
- init_done_o  out  1  high once the block is in RUN.

Behaviour:
- Reset: single clock clk; reset rst_n is asynchronous, active-low. While rst_n is low:
  - all outputs are 0;
  - FSM goes to INIT, or to RUN when INIT_ZERO=0;
  - init counter, in-flight flags and response buffers are cleared;
  - RR pointer is set to A.
- A reset asserted mid-operation discards in-flight reads and buffered responses; no response is emitted for them afterwards.
- INIT state:
  - Each cycle: ram_ce_o=1, ram_we_o=1, ram_addr_o=counter, ram_wd_o=0, ram_wmask_o=all ones.
  - The counter increments from 0 to WORD_DEPTH-1. After the write to the last address, the FSM goes to RUN.
  - a_ready_o and b_ready_o are 0. Exactly WORD_DEPTH init writes are issued.
  - init_done_o=1 from the first RUN cycle onward.
- RUN state, eligibility (combinational, per port p):
  - A write is eligible if p_v_i is high.
  - A read is eligible if p_v_i is high, no read from p is in flight, and (!p_rsp_v_o || p_rsp_ready_i).
- RUN state, arbitration:
  - If both ports are eligible, the RR pointer port wins.
  - If only one port is eligible, it wins.
  - After any grant, the pointer moves to the non-granted port. With no grant, the pointer holds.
- RUN state, grant:
  - p_ready_o=1 only for the winner, in the same cycle; at most one ready per cycle.
  - Macro pins carry the winner's fields combinationally, with ram_ce_o=1. With no grant, ram_ce_o=0 and the other ram_* outputs are don't-care.
- Write: completes in the grant cycle; no response is produced.
- Read timing (grant in cycle T):
  - The in-flight flag for p is set at the end of T.
  - In T+1, ram_rd_i is loaded into p's response buffer and the in-flight flag clears.
  - p_rsp_v_o=1 from T+2 and holds, with stable data, until p_rsp_ready_i is high.
  - Read-to-response latency is 2 cycles. Per-port read throughput is 1 per 2 cycles.
  - A buffer drained in the same cycle as a new grant is legal; the new data overwrites it at T+1.
- Same-address ordering: a write granted in T+1 does not affect read data from a T grant, because the macro latches on the T edge.
- p_rsp_ready_i while p_rsp_v_o=0 is ignored.
- Addresses are unchecked; out-of-range addresses are impossible at ADDR_WIDTH=10.

Test Plan:
- Reset, then count: exactly 1024 cycles with ram_we_o=1, addr 0..1023, wd=0, mask all ones; init_done_o rises on cycle 1025; a_ready_o=0 throughout.
- A writes 46'h1234_5678_9AB to addr 5 (full mask); A reads addr 5 -> a_rsp_v_o rises 2 cycles after the grant with data 46'h1234_5678_9AB.
- Partial mask: write all-ones to addr 7 with mask 46'h0000_0000_FFFF; read back -> 46'h0000_0000_FFFF, since the upper bits stay 0 from init.
- A and B hold valid continuously for 8 cycles, both writing -> grants alternate A,B,A,B..., 4 grants each, never both ready in the same cycle.
- A reads with a_rsp_ready_i=0 for 10 cycles -> a_rsp_v_o held and data stable; a further A read gets ready=0 until a_rsp_ready_i=1; meanwhile B writes keep being granted.
- Drop rst_n for 1 cycle in the cycle after an A read grant -> no A response ever appears; the init sweep restarts from addr 0.
